// File: rtl/vram_write_queue_if.sv
// CPU-write and VRAM-drain bundle for vram_write_queue; the slave modport is the queue side.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

interface vram_write_queue_if #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [7:0]            cpu_data;
  logic                  writable;
  logic                  overflow_clear;

  logic [ADDR_WIDTH-1:0] vram_address;
  logic [7:0]            vram_data;
  logic                  vram_write_enable;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport slave (
    input  cpu_write, cpu_address, cpu_data, writable, overflow_clear,
    output vram_address, vram_data, vram_write_enable, full, empty, count, overflow
  );

  modport master (
    output cpu_write, cpu_address, cpu_data, writable, overflow_clear,
    input  vram_address, vram_data, vram_write_enable, full, empty, count, overflow
  );
endinterface

// File: rtl/vram_write_queue.sv
// Buffers CPU VRAM writes and drains one per cycle while writable; 1-cycle minimum latency, no bypass.
// No backpressure to the CPU: writes arriving while full are dropped and flagged by sticky overflow.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_write_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH
) (
  input logic               clk,
  input logic               rst,
  vram_write_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          full, empty;
  logic          push, pop, drop;
  logic [EW-1:0] head;

  // Full/empty come straight from the registered count, so a drop is never
  // rescued by a pop in the same cycle.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = q.cpu_write && !full;
  assign drop  = q.cpu_write && full;
  assign pop   = !empty && q.writable;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop)                  overflow_d = 1'b1;
    else if (q.overflow_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {q.cpu_address, q.cpu_data};
  end

  assign q.vram_address      = head[EW-1:8];
  assign q.vram_data         = head[7:0];
  assign q.vram_write_enable = pop;
  assign q.full              = full;
  assign q.empty             = empty;
  assign q.count             = count_q;
  assign q.overflow          = overflow_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_CNT);
  a_full_empty:  assert property (@(posedge clk) disable iff (!rst) !(full && empty));
  a_we_writable: assert property (@(posedge clk) disable iff (!rst) pop |-> q.writable);
endmodule
